alu_mc: RTL and testbench
=========================

ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 SHALL provide parameter XLEN, default 32, giving the operand and result width; legal values are 8, 16, 32 and 64.
REQ-002 SHALL provide parameter SHW, default $clog2(XLEN), giving the number of shift-amount bits taken from b.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 start  in  1  request; sampled only when busy=0.
REQ-006 a  in  XLEN  operand A.
REQ-007 b  in  XLEN  operand B.
REQ-008 alu_op  in  4  operation code (see REQ-010).
REQ-009 The outputs SHALL be:
- busy  out  1: iterative operation in progress.
- done  out  1: one-cycle pulse, result valid.
- alu_out  out  XLEN: registered result.
- zero  out  1: registered, equals (alu_out==0).
- illegal  out  1: registered, set with done for an unsupported op.

Function
REQ-010 alu_op encoding SHALL be:
- 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR.
- 0101 SLL, 0110 SRL, 0111 SRA.
- 1000 SLT (signed), 1001 SLTU.
- 1010 MUL (low XLEN bits), 1011 DIVU, 1100 REMU.
- 1101-1111 illegal.
REQ-011 Arithmetic SHALL wrap modulo 2^XLEN; shifts SHALL use b[SHW-1:0] only; SLT and SLTU SHALL return 1 or 0 zero-extended to XLEN.
REQ-012 The FSM SHALL have three states:
- IDLE: waiting for start.
- CALC: iteration in progress, busy=1.
- FIN: one cycle, done=1, busy=0.
REQ-013 Single-cycle ops (0000-1001 and illegal) SHALL, on start in cycle N, move IDLE->FIN, with result and done in cycle N+1.
REQ-014 MUL, DIVU and REMU SHALL, on start in cycle N, move IDLE->CALC.
- busy=1 in cycles N+1..N+XLEN.
- FIN with done=1 in cycle N+XLEN+1.
REQ-015 MUL SHALL use radix-2 shift-add; DIVU and REMU SHALL use radix-2 restoring division; one iteration per CALC cycle.
REQ-016 Operands and alu_op SHALL be captured at start; input changes during CALC SHALL have no effect.
REQ-017 start while busy=1 SHALL be ignored, with no queuing.
REQ-018 start in FIN SHALL be accepted (back-to-back issue); the same transitions as from IDLE SHALL apply.
REQ-019 Divide by zero:
- DIVU SHALL return all-ones; REMU SHALL return a.
- Latency SHALL be the same as a normal divide.
- illegal SHALL stay 0.
REQ-020 Illegal ops SHALL return alu_out=0, zero=1, illegal=1.
REQ-021 alu_out, zero and illegal SHALL hold their values from one done pulse until the next done pulse.
REQ-022 done SHALL never be asserted together with busy.

Reset
REQ-023 rst_n=0 SHALL immediately force state=IDLE, busy=0, done=0, alu_out=0, zero=1 and illegal=0, and clear the iteration counter and datapath registers.
REQ-024 Reset during CALC SHALL abort the operation; no done pulse SHALL follow for that operation.
REQ-025 The first start SHALL be accepted on the first clock edge after rst_n deasserts.

Configuration
REQ-026 Macro ALU_MULDIV_EN SHALL control the iterative multiply/divide unit.
REQ-027 With ALU_MULDIV_EN defined, MUL, DIVU and REMU SHALL behave per REQ-014, REQ-015 and REQ-019.
REQ-028 Without ALU_MULDIV_EN:
- No multiply/divide datapath SHALL be present, and CALC SHALL be unreachable.
- Ops 1010-1100 SHALL be treated as illegal per REQ-013 and REQ-020.

Verification
REQ-029 ADD, a=5, b=7, start at N -> alu_out=12, zero=0, done=1 at N+1, busy never set.
REQ-030 SUB, a=b=0x1234 -> alu_out=0, zero=1; then SRA with a=0x80000000, b=0x24 -> alu_out=0xF8000000 (shift amount 4).
REQ-031 MUL, a=0xFFFFFFFF, b=2 -> busy for 32 cycles, then done at N+33 with alu_out=0xFFFFFFFE; toggling a and b during CALC does not change the result.
REQ-032 DIVU 100/7 -> alu_out=14; REMU 100/7 -> alu_out=2; DIVU x/0 -> 0xFFFFFFFF; REMU 9/0 -> 9.
REQ-033 MUL started, rst_n pulsed low at cycle N+10 -> outputs reset immediately and no done pulse follows; a new ADD issued after reset completes normally.
REQ-034 Without ALU_MULDIV_EN, MUL with a=3, b=4 -> done at N+1, alu_out=0, illegal=1; a start issued during a busy period is ignored (checked with the macro defined).

Source files
------------

// File: rtl/alu_mc.sv
// alu_mc: ALU with single-cycle logic/arith ops and an iterative MUL/DIVU/REMU unit (enabled by ALU_MULDIV_EN).
// Latency: single-cycle ops done at N+1; MUL/DIVU/REMU done at N+XLEN+1.
// Backpressure: start is ignored while busy, nothing is queued; start in the done cycle is accepted.
module alu_mc #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [3:0]      alu_op,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] alu_out,
    output logic            zero,
    output logic            illegal
);
    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLL  = 4'b0101;
    localparam logic [3:0] OP_SRL  = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_SLT  = 4'b1000;
    localparam logic [3:0] OP_SLTU = 4'b1001;
`ifdef ALU_MULDIV_EN
    localparam logic [3:0] OP_MUL  = 4'b1010;
    localparam logic [3:0] OP_DIVU = 4'b1011;
`endif

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;
    state_t state, state_nxt;

    logic            accept;
    logic            is_md;
    logic            sc_ill;
    logic [XLEN-1:0] sc_res;
    logic            md_last;

    assign accept = start && (state != CALC);
    assign busy   = (state == CALC);
    assign done   = (state == FIN);

    always_comb begin
        sc_res = '0;
        sc_ill = 1'b0;
        is_md  = 1'b0;
        case (alu_op)
            OP_ADD:  sc_res = a + b;
            OP_SUB:  sc_res = a - b;
            OP_AND:  sc_res = a & b;
            OP_OR:   sc_res = a | b;
            OP_XOR:  sc_res = a ^ b;
            OP_SLL:  sc_res = a << b[SHW-1:0];
            OP_SRL:  sc_res = a >> b[SHW-1:0];
            OP_SRA:  sc_res = $signed(a) >>> b[SHW-1:0];
            OP_SLT:  sc_res = XLEN'($signed(a) < $signed(b));
            OP_SLTU: sc_res = XLEN'(a < b);
`ifdef ALU_MULDIV_EN
            4'b1010, 4'b1011, 4'b1100: is_md = 1'b1;
`endif
            default: sc_ill = 1'b1;
        endcase
    end

`ifdef ALU_MULDIV_EN
    // md_acc: product accumulator / partial remainder; md_x: multiplier / dividend->quotient;
    // md_y: shifting multiplicand / divisor.
    logic [3:0]      md_op;
    logic [XLEN-1:0] md_acc, md_x, md_y;
    logic [SHW-1:0]  md_cnt;
    logic [XLEN-1:0] acc_nxt, x_nxt, y_nxt, md_res;
    logic [XLEN:0]   rem_sh;

    assign md_last = (md_cnt == '0);
    assign rem_sh  = {md_acc, md_x[XLEN-1]};

    always_comb begin
        acc_nxt = md_acc;
        x_nxt   = md_x;
        y_nxt   = md_y;
        if (md_op == OP_MUL) begin
            acc_nxt = md_x[0] ? md_acc + md_y : md_acc;
            x_nxt   = md_x >> 1;
            y_nxt   = md_y << 1;
        end else if (rem_sh >= {1'b0, md_y}) begin
            acc_nxt = XLEN'(rem_sh - {1'b0, md_y});
            x_nxt   = {md_x[XLEN-2:0], 1'b1};
        end else begin
            acc_nxt = rem_sh[XLEN-1:0];
            x_nxt   = {md_x[XLEN-2:0], 1'b0};
        end
        md_res = (md_op == OP_DIVU) ? x_nxt : acc_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md_op  <= '0;
            md_acc <= '0;
            md_x   <= '0;
            md_y   <= '0;
            md_cnt <= '0;
        end else if (accept && is_md) begin
            md_op  <= alu_op;
            md_acc <= '0;
            md_x   <= (alu_op == OP_MUL) ? b : a;
            md_y   <= (alu_op == OP_MUL) ? a : b;
            md_cnt <= SHW'(XLEN - 1);
        end else if (state == CALC) begin
            md_acc <= acc_nxt;
            md_x   <= x_nxt;
            md_y   <= y_nxt;
            md_cnt <= md_cnt - 1'b1;
        end
    end
`else
    assign md_last = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, FIN: begin
                if (start) state_nxt = is_md ? CALC : FIN;
                else       state_nxt = IDLE;
            end
            CALC:    if (md_last) state_nxt = FIN;
            default: state_nxt = IDLE;
        endcase
    end

    // Result registers only change on the edge that enters FIN, so they hold between done pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_out <= '0;
            zero    <= 1'b1;
            illegal <= 1'b0;
        end else if (accept && !is_md) begin
            alu_out <= sc_res;
            zero    <= (sc_res == '0);
            illegal <= sc_ill;
        end
`ifdef ALU_MULDIV_EN
        else if (state == CALC && md_last) begin
            alu_out <= md_res;
            zero    <= (md_res == '0);
            illegal <= 1'b0;
        end
`endif
    end
endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: directed vectors plus random ops against an arithmetic reference model.
module tb_alu_mc;
    localparam int XLEN = 32;
`ifdef ALU_MULDIV_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic [XLEN-1:0] a, b;
    logic [3:0]      alu_op;
    logic            busy, done, zero, illegal;
    logic [XLEN-1:0] alu_out;

    int tests = 0;
    int fails = 0;

    alu_mc #(.XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .alu_op(alu_op),
        .busy(busy), .done(done), .alu_out(alu_out), .zero(zero), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] r, output logic il, output int lat);
        logic signed [31:0] sx;
        sx  = x;
        r   = '0;
        il  = 1'b0;
        lat = 1;
        case (op)
            4'd0: r = x + y;
            4'd1: r = x - y;
            4'd2: r = x & y;
            4'd3: r = x | y;
            4'd4: r = x ^ y;
            4'd5: r = x << y[4:0];
            4'd6: r = x >> y[4:0];
            4'd7: r = sx >>> y[4:0];
            4'd8: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            4'd9: r = (x < y) ? 32'd1 : 32'd0;
            4'd10, 4'd11, 4'd12: begin
                if (MD) begin
                    lat = XLEN + 1;
                    if (op == 4'd10)      r = x * y;
                    else if (op == 4'd11) r = (y == 0) ? 32'hFFFF_FFFF : x / y;
                    else                  r = (y == 0) ? x : x % y;
                end else begin
                    il = 1'b1;
                end
            end
            default: il = 1'b1;
        endcase
    endfunction

    // Issue one op just after a falling edge, scramble inputs while waiting, then check result and timing.
    task automatic do_op(input string tag, input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        logic [31:0] er;
        logic        ei;
        int          el, cyc, nbusy;
        model(op, x, y, er, ei, el);
        start = 1'b1; alu_op = op; a = x; b = y;
        @(negedge clk);
        start = 1'b0;
        cyc = 1; nbusy = 0;
        while (!done && cyc < XLEN + 10) begin
            if (busy) nbusy++;
            a = $urandom; b = $urandom; alu_op = 4'($urandom);
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_done"}, done, 1);
        chk({tag, "_latency"}, cyc, el);
        chk({tag, "_busy_cycles"}, nbusy, el - 1);
        chk({tag, "_busy_with_done"}, busy, 0);
        chk({tag, "_alu_out"}, alu_out, er);
        chk({tag, "_zero"}, zero, (er == 0));
        chk({tag, "_illegal"}, illegal, ei);
        @(negedge clk);
        chk({tag, "_done_pulse"}, done, 0);
        chk({tag, "_hold"}, alu_out, er);
    endtask

    initial begin
        int ndone, cyc;
        logic [3:0]  rop;
        logic [31:0] rx, ry;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; alu_op = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_alu_out", alu_out, 0);
        chk("rst_zero", zero, 1);
        chk("rst_illegal", illegal, 0);

        rst_n = 1'b1;
        do_op("add_5_7", 4'd0, 32'd5, 32'd7);
        chk("add_5_7_const", alu_out, 32'd12);
        do_op("sub_eq", 4'd1, 32'h1234, 32'h1234);
        do_op("sra", 4'd7, 32'h8000_0000, 32'h24);
        chk("sra_const", alu_out, 32'hF800_0000);
        do_op("slt_neg", 4'd8, 32'hFFFF_FFFF, 32'd1);
        do_op("sltu_neg", 4'd9, 32'hFFFF_FFFF, 32'd1);
        do_op("mul_ff_2", 4'd10, 32'hFFFF_FFFF, 32'd2);
        do_op("divu_100_7", 4'd11, 32'd100, 32'd7);
        do_op("remu_100_7", 4'd12, 32'd100, 32'd7);
        do_op("divu_by0", 4'd11, 32'h1357_9BDF, 32'd0);
        do_op("remu_9_0", 4'd12, 32'd9, 32'd0);
        do_op("mul_3_4", 4'd10, 32'd3, 32'd4);
        do_op("illegal_op", 4'd14, 32'd3, 32'd4);

        // Back-to-back: start held through the done cycle.
        start = 1'b1; alu_op = 4'd0; a = 32'd10; b = 32'd20;
        @(negedge clk);
        chk("b2b_done1", done, 1);
        chk("b2b_res1", alu_out, 32'd30);
        alu_op = 4'd1; a = 32'd50; b = 32'd8;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_done2", done, 1);
        chk("b2b_res2", alu_out, 32'd42);
        @(negedge clk);

`ifdef ALU_MULDIV_EN
        // A start during CALC must be dropped, not queued.
        start = 1'b1; alu_op = 4'd10; a = 32'd3; b = 32'd5;
        @(negedge clk);
        start = 1'b0; cyc = 1;
        repeat (4) begin @(negedge clk); cyc++; end
        start = 1'b1; alu_op = 4'd0; a = 32'd1; b = 32'd1;
        @(negedge clk);
        start = 1'b0; cyc++;
        while (!done && cyc < XLEN + 10) begin @(negedge clk); cyc++; end
        chk("busy_start_latency", cyc, XLEN + 1);
        chk("busy_start_result", alu_out, 32'd15);
        ndone = 0;
        repeat (5) begin @(negedge clk); if (done) ndone++; end
        chk("busy_start_not_queued", ndone, 0);
`endif

        // Reset in the middle of a multiply.
        start = 1'b1; alu_op = 4'd10; a = 32'hFFFF_FFFF; b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_alu_out", alu_out, 0);
        chk("mid_rst_zero", zero, 1);
        chk("mid_rst_illegal", illegal, 0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        repeat (XLEN + 5) begin @(negedge clk); if (done) ndone++; end
        chk("mid_rst_no_done", ndone, 0);
        do_op("add_after_rst", 4'd0, 32'd100, 32'd23);

        for (int i = 0; i < 40; i++) begin
            rop = 4'($urandom_range(0, 15));
            rx  = $urandom;
            case ($urandom_range(0, 3))
                0:       ry = 32'd0;
                1:       ry = 32'($urandom_range(1, 300));
                default: ry = $urandom;
            endcase
            do_op("rand", rop, rx, ry);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
